// File: rtl/bcd_pulse_gen_if.sv
// Control/status bundle for bcd_pulse_gen: setpoint digits, commands, waveform and live BCD count.
interface bcd_pulse_gen_if;
    logic [3:0] bcd_hi;
    logic [3:0] bcd_lo;
    logic       load;
    logic       start;
    logic       stop;
    logic       mode;
    logic       wave;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] cnt_hi;
    logic [3:0] cnt_lo;

    // Controller side: issues setpoint and commands, observes waveform and count.
    modport master (
        output bcd_hi, bcd_lo, load, start, stop, mode,
        input  wave, busy, done, err, cnt_hi, cnt_lo
    );

    // Generator side.
    modport slave (
        input  bcd_hi, bcd_lo, load, start, stop, mode,
        output wave, busy, done, err, cnt_hi, cnt_lo
    );
endinterface

// File: rtl/bcd_pulse_gen.sv
// Square-wave / single-pulse generator whose phase length is a 2-digit BCD count of base ticks.
// A base tick is PRESCALE clk cycles; the live BCD down-count is exported for 7-segment display.
module bcd_pulse_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_pulse_gen_if.slave bus
);

    localparam int unsigned   PW   = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e        state_q;
    logic [3:0]    set_hi_q, set_lo_q;
    logic [3:0]    cnt_hi_q, cnt_lo_q;
    logic [PW-1:0] presc_q;
    logic          wave_q, busy_q, done_q, err_q, mode_q;

    logic          load_ok, load_bad;
    logic [3:0]    set_hi_nxt, set_lo_nxt;
    logic          set_zero, tick, last;
    logic [3:0]    dec_hi, dec_lo;

    // Setpoint capture qualification, tick detection and BCD decrement with borrow.
    always_comb begin
        load_ok    = bus.load && (bus.bcd_hi <= 4'd9) && (bus.bcd_lo <= 4'd9);
        load_bad   = bus.load && ((bus.bcd_hi > 4'd9) || (bus.bcd_lo > 4'd9));
        set_hi_nxt = load_ok ? bus.bcd_hi : set_hi_q;
        set_lo_nxt = load_ok ? bus.bcd_lo : set_lo_q;
        set_zero   = (set_hi_q == 4'd0) && (set_lo_q == 4'd0);
        tick       = (presc_q == PMAX);
        last       = (cnt_hi_q == 4'd0) && (cnt_lo_q == 4'd1);
        if (cnt_lo_q == 4'd0) begin
            dec_lo = 4'd9;
            dec_hi = cnt_hi_q - 4'd1;
        end else begin
            dec_lo = cnt_lo_q - 4'd1;
            dec_hi = cnt_hi_q;
        end
    end

    // Single FSM register block: state, setpoint, counter, prescaler and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            set_hi_q <= 4'd0;
            set_lo_q <= 4'd0;
            cnt_hi_q <= 4'd0;
            cnt_lo_q <= 4'd0;
            presc_q  <= '0;
            wave_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            set_hi_q <= set_hi_nxt;
            set_lo_q <= set_lo_nxt;
            if (load_ok)  err_q <= 1'b0;
            if (load_bad) err_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    // Idle display tracks the setpoint, including a load on this edge.
                    cnt_hi_q <= set_hi_nxt;
                    cnt_lo_q <= set_lo_nxt;
                    presc_q  <= '0;
                    wave_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        if (set_zero) begin
                            err_q <= 1'b1;
                        end else begin
                            // Start uses the setpoint registered before this edge.
                            state_q  <= StHigh;
                            wave_q   <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_hi_q <= set_hi_q;
                            cnt_lo_q <= set_lo_q;
                            mode_q   <= bus.mode;
                        end
                    end
                end

                StHigh, StLow: begin
                    if (bus.stop) begin
                        state_q  <= StIdle;
                        wave_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        presc_q  <= '0;
                        cnt_hi_q <= set_hi_nxt;
                        cnt_lo_q <= set_lo_nxt;
                    end else if (!tick) begin
                        presc_q <= presc_q + PW'(1);
                    end else begin
                        presc_q <= '0;
                        if (!last) begin
                            cnt_hi_q <= dec_hi;
                            cnt_lo_q <= dec_lo;
                        end else if ((state_q == StHigh) && mode_q) begin
                            // Single pulse complete.
                            state_q  <= StIdle;
                            wave_q   <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            cnt_hi_q <= set_hi_nxt;
                            cnt_lo_q <= set_lo_nxt;
                        end else if (set_zero) begin
                            // A 00 setpoint loaded mid-run cannot be reloaded; abort rather
                            // than let the counter underflow.
                            state_q  <= StIdle;
                            wave_q   <= 1'b0;
                            busy_q   <= 1'b0;
                            err_q    <= 1'b1;
                            cnt_hi_q <= set_hi_nxt;
                            cnt_lo_q <= set_lo_nxt;
                        end else begin
                            cnt_hi_q <= set_hi_q;
                            cnt_lo_q <= set_lo_q;
                            if (state_q == StHigh) begin
                                state_q <= StLow;
                                wave_q  <= 1'b0;
                            end else begin
                                state_q <= StHigh;
                                wave_q  <= 1'b1;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                    wave_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wave   = wave_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.cnt_hi = cnt_hi_q;
    assign bus.cnt_lo = cnt_lo_q;

endmodule

// File: tb/tb_bcd_pulse_gen.sv
// Self-checking bench for bcd_pulse_gen: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_bcd_pulse_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bcd_pulse_gen_if if1 ();
    bcd_pulse_gen_if if4 ();

    bcd_pulse_gen #(.PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    bcd_pulse_gen #(.PRESCALE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wave;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic exp_t obs1();
        return {if1.wave, if1.busy, if1.done, if1.cnt_hi, if1.cnt_lo};
    endfunction

    function automatic exp_t obs4();
        return {if4.wave, if4.busy, if4.done, if4.cnt_hi, if4.cnt_lo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        if1.bcd_hi = 4'd0; if1.bcd_lo = 4'd0; if1.load = 1'b0;
        if1.start  = 1'b0; if1.stop   = 1'b0; if1.mode = 1'b0;
        if4.bcd_hi = 4'd0; if4.bcd_lo = 4'd0; if4.load = 1'b0;
        if4.start  = 1'b0; if4.stop   = 1'b0; if4.mode = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] o;
        rst_n = 1'b0;
        if1.start = 1'b1; if1.load = 1'b1; if1.bcd_hi = 4'd1; if1.bcd_lo = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            o = {if1.wave, if1.busy, if1.done, if1.err, if1.cnt_hi, if1.cnt_lo};
            checks++;
            if (o !== 12'h000) begin
                failures++;
                $display("FAIL reset_hold%0d: got %h expected 000", i, o);
            end
        end
        o = {if4.wave, if4.busy, if4.done, if4.err, if4.cnt_hi, if4.cnt_lo};
        checks++;
        if (o !== 12'h000) begin
            failures++;
            $display("FAIL reset_p4: got %h expected 000", o);
        end
        clr_inputs();
        rst_n = 1'b1;
        step();
        if1.load = 1'b1; if1.bcd_hi = 4'd1; if1.bcd_lo = 4'd2;
        step();
        if1.load = 1'b0;
        checks++;
        if ({if1.err, if1.cnt_hi, if1.cnt_lo} !== 9'h012) begin
            failures++;
            $display("FAIL load_12: got err=%b cnt=%h%h expected err=0 cnt=12",
                     if1.err, if1.cnt_hi, if1.cnt_lo);
        end
    endtask

    task automatic test_continuous();
        exp_t e, o;
        if1.load = 1'b1; if1.bcd_hi = 4'd0; if1.bcd_lo = 4'd3;
        step();
        if1.load = 1'b0;
        // Expected: N=3, P=1 -> 3 high, 3 low, Done on each re-entry to high.
        for (int k = 0; k < 18; k++) begin
            e.wave = ((k / 3) % 2) == 0;
            e.busy = 1'b1;
            e.done = (k > 0) && ((k % 6) == 0);
            e.cnt  = to_bcd(3 - (k % 3));
            sb.push_back(e);
        end
        if1.start = 1'b1; if1.mode = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            if1.start = 1'b0;
            e = sb.pop_front();
            o = obs1();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL cont_k%0d: got w/b/d/cnt=%b%b%b/%h expected %b%b%b/%h",
                         k, o.wave, o.busy, o.done, o.cnt, e.wave, e.busy, e.done, e.cnt);
            end
        end
        if1.stop = 1'b1;
        step();
        if1.stop = 1'b0;
        checks++;
        if ({if1.wave, if1.busy, if1.done} !== 3'b000) begin
            failures++;
            $display("FAIL cont_stop: got w/b/d=%b%b%b expected 000", if1.wave, if1.busy, if1.done);
        end
    endtask

    task automatic test_single();
        exp_t e, o;
        if4.load = 1'b1; if4.bcd_hi = 4'd1; if4.bcd_lo = 4'd0;
        step();
        if4.load = 1'b0;
        checks++;
        if ({if4.cnt_hi, if4.cnt_lo} !== 8'h10) begin
            failures++;
            $display("FAIL single_load: got %h%h expected 10", if4.cnt_hi, if4.cnt_lo);
        end
        for (int k = 0; k < 40; k++) begin
            e.wave = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.cnt = to_bcd(10 - k / 4);
            sb.push_back(e);
        end
        e.wave = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.cnt = 8'h10;
        sb.push_back(e);
        e.done = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        if4.start = 1'b1; if4.mode = 1'b1;
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            if4.start = 1'b0; if4.mode = 1'b0;
            e = sb.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_k%0d: got w/b/d/cnt=%b%b%b/%h expected %b%b%b/%h",
                         k, o.wave, o.busy, o.done, o.cnt, e.wave, e.busy, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_errors();
        if1.load = 1'b1; if1.bcd_hi = 4'hA; if1.bcd_lo = 4'd3;
        step();
        checks++;
        if ({if1.err, if1.cnt_hi, if1.cnt_lo} !== 9'h103) begin
            failures++;
            $display("FAIL err_bad_digit: got err=%b cnt=%h%h expected err=1 cnt=03",
                     if1.err, if1.cnt_hi, if1.cnt_lo);
        end
        if1.bcd_hi = 4'd0; if1.bcd_lo = 4'd0;
        step();
        if1.load = 1'b0;
        checks++;
        if ({if1.err, if1.cnt_hi, if1.cnt_lo} !== 9'h000) begin
            failures++;
            $display("FAIL err_load00: got err=%b cnt=%h%h expected err=0 cnt=00",
                     if1.err, if1.cnt_hi, if1.cnt_lo);
        end
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({if1.err, if1.wave, if1.busy} !== 3'b100) begin
                failures++;
                $display("FAIL err_start00_%0d: got err/w/b=%b%b%b expected 100",
                         i, if1.err, if1.wave, if1.busy);
            end
            step();
        end
        if1.load = 1'b1; if1.bcd_hi = 4'd0; if1.bcd_lo = 4'd5;
        step();
        if1.load = 1'b0;
        checks++;
        if ({if1.err, if1.cnt_hi, if1.cnt_lo} !== 9'h005) begin
            failures++;
            $display("FAIL err_clear05: got err=%b cnt=%h%h expected err=0 cnt=05",
                     if1.err, if1.cnt_hi, if1.cnt_lo);
        end
    endtask

    task automatic test_midrun();
        exp_t e, o;
        logic [7:0] cnts [8];
        cnts = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
        for (int k = 0; k < 8; k++) begin
            e.wave = (k < 5) || (k == 7);
            e.busy = 1'b1;
            e.done = (k == 7);
            e.cnt  = cnts[k];
            sb.push_back(e);
        end
        if1.start = 1'b1; if1.mode = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            step();
            if1.start = 1'b0;
            if1.load  = (k == 1);
            if1.bcd_hi = 4'd0; if1.bcd_lo = 4'd2;
            e = sb.pop_front();
            o = obs1();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midrun_k%0d: got w/b/d/cnt=%b%b%b/%h expected %b%b%b/%h",
                         k, o.wave, o.busy, o.done, o.cnt, e.wave, e.busy, e.done, e.cnt);
            end
        end
        if1.load = 1'b0;
    endtask

    task automatic test_abort();
        logic [11:0] o;
        if1.stop = 1'b1; if1.start = 1'b1;
        step();
        if1.stop = 1'b0; if1.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({if1.wave, if1.busy, if1.done, if1.cnt_hi, if1.cnt_lo} !== 11'h002) begin
                failures++;
                $display("FAIL abort_stop%0d: got w/b/d=%b%b%b cnt=%h%h expected 000 cnt=02",
                         i, if1.wave, if1.busy, if1.done, if1.cnt_hi, if1.cnt_lo);
            end
            step();
        end
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        step();
        step();
        checks++;
        if ({if1.wave, if1.busy, if1.cnt_hi, if1.cnt_lo} !== 10'h102) begin
            failures++;
            $display("FAIL abort_in_low: got w/b=%b%b cnt=%h%h expected 01 cnt=02",
                     if1.wave, if1.busy, if1.cnt_hi, if1.cnt_lo);
        end
        rst_n = 1'b0;
        step();
        o = {if1.wave, if1.busy, if1.done, if1.err, if1.cnt_hi, if1.cnt_lo};
        checks++;
        if (o !== 12'h000) begin
            failures++;
            $display("FAIL abort_reset: got %h expected 000", o);
        end
        rst_n = 1'b1;
        step();
        step();
        o = {if1.wave, if1.busy, if1.done, if1.err, if1.cnt_hi, if1.cnt_lo};
        checks++;
        if (o !== 12'h000) begin
            failures++;
            $display("FAIL abort_setpoint00: got %h expected 000", o);
        end
    endtask

    initial begin
        clr_inputs();
        test_reset();
        test_continuous();
        test_single();
        test_errors();
        test_midrun();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
